// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo: multicycle control FSM (fetch/decode/execute/memory/writeback); optional MEM_TIMEOUT_EN memory timeout
module unidade_controle_multiciclo #(
    parameter int TIMEOUT_CICLOS = 16,
    parameter int LARG_TIMEOUT   = 5
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [3:0] Cond,
    input  logic [7:0] Opcode,
    input  logic [3:0] Flags,
    input  logic       InstrPronto,
    input  logic       MemPronto,
    output logic       InstrLeitura,
    output logic       IREscrita,
    output logic       PCEscrita,
    output logic       SelPCDesvio,
    output logic       RegEscrita,
    output logic       SelRegDado,
    output logic       MemLeitura,
    output logic       MemEscrita,
    output logic       FlagsEscrita,
    output logic       Parado,
    output logic       ErroMem,
    output logic [2:0] Estado
);
    typedef enum logic [2:0] {
        INICIO     = 3'd0,
        BUSCA      = 3'd1,
        DECODIFICA = 3'd2,
        EXECUTA    = 3'd3,
        MEMORIA    = 3'd4,
        ESCRITA    = 3'd5,
        PARADO     = 3'd6
    } estado_t;

    estado_t    estado_q, estado_d;
    logic [7:0] opcode_q, opcode_d;
    logic       cond_ok_q, cond_ok_d;
    logic       esgotado;
    logic       unused;

    function automatic logic avalia_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign Estado = estado_q;
    assign unused = opcode_q[1];
    assign opcode_d  = (estado_q == DECODIFICA) ? Opcode : opcode_q;
    assign cond_ok_d = (estado_q == DECODIFICA) ? avalia_cond(Cond, Flags) : cond_ok_q;

`ifdef MEM_TIMEOUT_EN
    logic [LARG_TIMEOUT-1:0] cont_q, cont_d;
    logic                    erro_q, erro_d;
    assign esgotado = (cont_q == LARG_TIMEOUT'(TIMEOUT_CICLOS)) && !MemPronto;
    assign cont_d   = (estado_q != MEMORIA) ? '0 : cont_q + LARG_TIMEOUT'(!MemPronto);
    assign erro_d   = erro_q || (estado_q == MEMORIA && esgotado);
    assign ErroMem  = erro_q;
    // wait counter held at zero outside MEMORIA; sticky timeout flag
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cont_q <= '0;
            erro_q <= 1'b0;
        end else begin
            cont_q <= cont_d;
            erro_q <= erro_d;
        end
    end
`else
    localparam int unused_cfg = TIMEOUT_CICLOS + LARG_TIMEOUT;
    assign esgotado = 1'b0;
    assign ErroMem  = 1'b0;
`endif

    // state register and decode fields latched in DECODIFICA
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            estado_q  <= INICIO;
            opcode_q  <= '0;
            cond_ok_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            opcode_q  <= opcode_d;
            cond_ok_q <= cond_ok_d;
        end
    end

    // next state and control enables; only the fetch/memory waits look at the ready inputs
    always_comb begin
        estado_d     = estado_q;
        InstrLeitura = 1'b0;
        IREscrita    = 1'b0;
        PCEscrita    = 1'b0;
        SelPCDesvio  = 1'b0;
        RegEscrita   = 1'b0;
        SelRegDado   = 1'b0;
        MemLeitura   = 1'b0;
        MemEscrita   = 1'b0;
        FlagsEscrita = 1'b0;
        Parado       = 1'b0;
        case (estado_q)
            INICIO: estado_d = BUSCA;
            BUSCA: begin
                InstrLeitura = 1'b1;
                IREscrita    = InstrPronto;
                estado_d     = InstrPronto ? DECODIFICA : BUSCA;
            end
            DECODIFICA: estado_d = EXECUTA;
            EXECUTA: begin
                if (!cond_ok_q) begin
                    PCEscrita = 1'b1;
                    estado_d  = BUSCA;
                end else begin
                    case (opcode_q[7:6])
                        2'b00: begin
                            FlagsEscrita = opcode_q[0];
                            estado_d     = ESCRITA;
                        end
                        2'b01: begin
                            PCEscrita   = 1'b1;
                            SelPCDesvio = 1'b1;
                            RegEscrita  = opcode_q[4];
                            estado_d    = BUSCA;
                        end
                        2'b10: estado_d = MEMORIA;
                        default: estado_d = (opcode_q[5:2] == 4'hF) ? PARADO : ESCRITA;
                    endcase
                end
            end
            MEMORIA: begin
                MemLeitura = opcode_q[3] && !esgotado;
                MemEscrita = !opcode_q[3] && !esgotado;
                PCEscrita  = (MemPronto && !opcode_q[3]) || esgotado;
                estado_d   = MemPronto ? (opcode_q[3] ? ESCRITA : BUSCA) : (esgotado ? BUSCA : MEMORIA);
            end
            ESCRITA: begin
                RegEscrita = 1'b1;
                SelRegDado = opcode_q[3] && (opcode_q[7:6] == 2'b10);
                PCEscrita  = 1'b1;
                estado_d   = BUSCA;
            end
            PARADO: Parado = 1'b1;
            default: estado_d = INICIO;
        endcase
    end
endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// tb_unidade_controle_multiciclo: table-driven scoreboard bench for the multicycle control FSM
module tb_unidade_controle_multiciclo;
    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic [3:0] Cond = '0;
    logic [7:0] Opcode = '0;
    logic [3:0] Flags = '0;
    logic       InstrPronto = 1'b0;
    logic       MemPronto = 1'b0;
    logic       InstrLeitura, IREscrita, PCEscrita, SelPCDesvio, RegEscrita, SelRegDado;
    logic       MemLeitura, MemEscrita, FlagsEscrita, Parado, ErroMem;
    logic [2:0] Estado;
    logic [13:0] saida;

    always #5 Clock = ~Clock;

    unidade_controle_multiciclo #(.TIMEOUT_CICLOS(16), .LARG_TIMEOUT(5)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Cond(Cond), .Opcode(Opcode), .Flags(Flags),
        .InstrPronto(InstrPronto), .MemPronto(MemPronto), .InstrLeitura(InstrLeitura),
        .IREscrita(IREscrita), .PCEscrita(PCEscrita), .SelPCDesvio(SelPCDesvio),
        .RegEscrita(RegEscrita), .SelRegDado(SelRegDado), .MemLeitura(MemLeitura),
        .MemEscrita(MemEscrita), .FlagsEscrita(FlagsEscrita), .Parado(Parado),
        .ErroMem(ErroMem), .Estado(Estado)
    );

    assign saida = {Estado, InstrLeitura, IREscrita, PCEscrita, SelPCDesvio, RegEscrita,
                    SelRegDado, MemLeitura, MemEscrita, FlagsEscrita, Parado, ErroMem};

    localparam logic [10:0] B_EM = 11'd1, B_PAR = 11'd2, B_FW = 11'd4, B_MW = 11'd8,
                            B_ML = 11'd16, B_SRD = 11'd32, B_RW = 11'd64, B_SEL = 11'd128,
                            B_PC = 11'd256, B_IR = 11'd512, B_IL = 11'd1024;

    typedef struct {
        logic        ip;
        logic        mp;
        logic [13:0] exp;
        string       nome;
    } passo_t;

    typedef struct {
        logic [3:0] cond;
        logic [7:0] op;
        logic [3:0] flags;
        int         idly;
        int         mdly;
        logic       ruido;
    } vetor_t;

    passo_t fila[$];
    vetor_t tab[23];
    int     erros = 0;
    int     checks = 0;
    logic   erro_exp = 1'b0;

    function automatic logic [13:0] mk(input logic [2:0] e, input logic [10:0] m);
        return {e, m | (erro_exp ? B_EM : 11'd0)};
    endfunction

    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy & !z;
            4'h9: return !cy | z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z & (n == v);
            4'hD: return z | (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input logic ip, input logic mp, input logic [2:0] e, input logic [10:0] m, input string nome);
        passo_t p;
        p.ip = ip; p.mp = mp; p.exp = mk(e, m); p.nome = nome;
        fila.push_back(p);
    endtask

    task automatic check(input string nome, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            erros++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nome, got, exp, $time);
        end
    endtask

    task automatic drenar();
        passo_t p;
        while (fila.size() > 0) begin
            p = fila.pop_front();
            InstrPronto = p.ip;
            MemPronto = p.mp;
            @(negedge Clock);
            check(p.nome, saida, p.exp);
            @(posedge Clock);
            #1;
        end
        InstrPronto = 1'b0;
        MemPronto = 1'b0;
    endtask

    task automatic montar(input vetor_t v);
        logic       ld;
        logic [3:0] sub;
        logic       r;
        r = v.ruido;
        sub = v.op[5:2];
        ld = v.op[3];
        for (int i = 0; i < v.idly; i++) push(1'b0, 1'b0, 3'd1, B_IL, "busca_espera");
        push(1'b1, 1'b0, 3'd1, B_IL | B_IR, "busca_pronto");
        push(r, r, 3'd2, 11'd0, "decodifica");
        if (!cond_ref(v.cond, v.flags)) begin
            push(r, r, 3'd3, B_PC, "executa_anulada");
        end else begin
            case (v.op[7:6])
                2'b00: begin
                    push(r, r, 3'd3, v.op[0] ? B_FW : 11'd0, "executa_d");
                    push(r, r, 3'd5, B_RW | B_PC, "escrita_d");
                end
                2'b01: push(r, r, 3'd3, B_PC | B_SEL | (v.op[4] ? B_RW : 11'd0), "executa_b");
                2'b10: begin
                    push(r, r, 3'd3, 11'd0, "executa_m");
                    for (int i = 0; i < v.mdly; i++) push(1'b0, 1'b0, 3'd4, ld ? B_ML : B_MW, "memoria_espera");
                    push(1'b0, 1'b1, 3'd4, ld ? B_ML : (B_MW | B_PC), "memoria_pronta");
                    if (ld) push(r, r, 3'd5, B_RW | B_SRD | B_PC, "escrita_load");
                end
                default: begin
                    push(r, r, 3'd3, 11'd0, "executa_a");
                    if (sub != 4'hF) push(r, r, 3'd5, B_RW | B_PC, "escrita_a");
                end
            endcase
        end
    endtask

    task automatic reinicia();
        Reset_n = 1'b0;
        erro_exp = 1'b0;
        InstrPronto = 1'b1;
        MemPronto = 1'b1;
        @(negedge Clock);
        check("reset", saida, 14'd0);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        InstrPronto = 1'b0;
        MemPronto = 1'b0;
        @(negedge Clock);
        check("inicio", saida, 14'd0);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        tab[0]  = '{4'hE, 8'h01, 4'b0000, 3, 0, 1'b0};
        tab[1]  = '{4'h0, 8'h88, 4'b0000, 0, 0, 1'b0};
        tab[2]  = '{4'h0, 8'h88, 4'b0100, 0, 2, 1'b0};
        tab[3]  = '{4'hE, 8'h50, 4'b0000, 1, 0, 1'b0};
        tab[4]  = '{4'hE, 8'h80, 4'b0000, 0, 1, 1'b0};
        tab[5]  = '{4'hE, 8'h40, 4'b0000, 0, 0, 1'b1};
        tab[6]  = '{4'hE, 8'hC0, 4'b0000, 0, 0, 1'b0};
        tab[7]  = '{4'h1, 8'h00, 4'b0000, 0, 0, 1'b0};
        tab[8]  = '{4'h2, 8'h00, 4'b0010, 0, 0, 1'b0};
        tab[9]  = '{4'h3, 8'h80, 4'b0010, 0, 0, 1'b0};
        tab[10] = '{4'h4, 8'h01, 4'b1000, 0, 0, 1'b0};
        tab[11] = '{4'h5, 8'h01, 4'b1000, 0, 0, 1'b0};
        tab[12] = '{4'h6, 8'hC4, 4'b0001, 0, 0, 1'b0};
        tab[13] = '{4'h7, 8'h50, 4'b0001, 0, 0, 1'b0};
        tab[14] = '{4'h8, 8'h00, 4'b0010, 0, 0, 1'b0};
        tab[15] = '{4'h9, 8'h00, 4'b0010, 0, 0, 1'b0};
        tab[16] = '{4'hA, 8'h00, 4'b1001, 0, 0, 1'b0};
        tab[17] = '{4'hB, 8'h00, 4'b1001, 0, 0, 1'b0};
        tab[18] = '{4'hC, 8'h00, 4'b0000, 0, 0, 1'b0};
        tab[19] = '{4'hD, 8'h00, 4'b0000, 0, 0, 1'b0};
        tab[20] = '{4'hF, 8'h00, 4'b0000, 0, 0, 1'b0};
        tab[21] = '{4'hE, 8'h88, 4'b0000, 0, 0, 1'b1};
        tab[22] = '{4'hF, 8'hFC, 4'b0000, 0, 0, 1'b0};

        reinicia();
        for (int k = 0; k < 23; k++) begin
            Cond = tab[k].cond;
            Opcode = tab[k].op;
            Flags = tab[k].flags;
            montar(tab[k]);
            drenar();
        end

        Cond = 4'hE;
        Opcode = 8'hFC;
        push(1'b1, 1'b0, 3'd1, B_IL | B_IR, "halt_busca");
        push(1'b0, 1'b0, 3'd2, 11'd0, "halt_decodifica");
        push(1'b0, 1'b0, 3'd3, 11'd0, "halt_executa");
        for (int i = 0; i < 3; i++) push(1'b1, 1'b1, 3'd6, B_PAR, "parado");
        drenar();

        reinicia();
        Opcode = 8'h80;
        push(1'b1, 1'b0, 3'd1, B_IL | B_IR, "st_busca");
        push(1'b0, 1'b0, 3'd2, 11'd0, "st_decodifica");
        push(1'b0, 1'b0, 3'd3, 11'd0, "st_executa");
        push(1'b0, 1'b0, 3'd4, B_MW, "st_espera");
        push(1'b0, 1'b0, 3'd4, B_MW, "st_espera");
        drenar();
        #2;
        check("st_antes_reset", saida, mk(3'd4, B_MW));
        Reset_n = 1'b0;
        #1;
        check("reset_em_memoria", saida, 14'd0);
        MemPronto = 1'b1;
        @(posedge Clock);
        #1;
        check("reset_mantido", saida, 14'd0);
        reinicia();

`ifdef MEM_TIMEOUT_EN
        Opcode = 8'h88;
        push(1'b1, 1'b0, 3'd1, B_IL | B_IR, "to_busca");
        push(1'b0, 1'b0, 3'd2, 11'd0, "to_decodifica");
        push(1'b0, 1'b0, 3'd3, 11'd0, "to_executa");
        for (int i = 0; i < 16; i++) push(1'b0, 1'b0, 3'd4, B_ML, "to_espera");
        push(1'b0, 1'b0, 3'd4, B_PC, "to_esgotado");
        erro_exp = 1'b1;
        push(1'b0, 1'b0, 3'd1, B_IL, "to_volta_busca");
        push(1'b0, 1'b0, 3'd1, B_IL, "to_erro_fixo");
        drenar();
        reinicia();
`endif

        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end
endmodule
